rng_request_arbiter: RTL and testbench

- Shares the single latched-counter random source among NUM_REQ game requesters: enemy-car spawner, fuel spawner, lane picker, and so on.
- Arbitrates requests round-robin and generates the one-cycle rising-edge `rise` pulse into the generator.
- Captures the generator's `dout` and returns it to the granted requester with a one-hot ack.
- Sits in the game controller between the spawn logic and the random source.

---
 rtl/rng_arb_pkg.sv | 23 ++
 rtl/rr_arbiter_core.sv | 32 +++
 rtl/rng_request_arbiter.sv | 108 ++++++++++
 tb/tb_rng_request_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rng_arb_pkg.sv
// Shared types and helpers for the random-source request arbiter.
package rng_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        CAPTURE = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int DEF_RAND_W  = 6;
    localparam int DEF_NUM_REQ = 4;

    // Index of the set bit in a one-hot vector of up to 8 bits.
    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx[0] = v[1] | v[3] | v[5] | v[7];
        idx[1] = v[2] | v[3] | v[6] | v[7];
        idx[2] = v[4] | v[5] | v[6] | v[7];
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter_core
    import rng_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   rot_pick;
    logic [2:0]           ofs;
    logic [IDX_W:0]       sum;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, then un-rotate.
    assign dbl      = {req, req};
    assign rot      = NUM_REQ'(dbl >> ptr);
    assign rot_pick = rot & (~rot + 1'b1);
    assign ofs      = onehot_index(8'(rot_pick));
    assign sum      = {1'b0, ptr} + (IDX_W + 1)'(ofs);

    assign winner = (sum >= NUM_L) ? IDX_W'(sum - NUM_L) : IDX_W'(sum);
    assign valid  = |req;

endmodule

// File: rtl/rng_request_arbiter.sv
// Round-robin sharing of the latched-counter random source among NUM_REQ requesters.
// Optional duplicate rejection per requester under `RNG_REJECT_DUP_EN.
module rng_request_arbiter
    import rng_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int RAND_W    = DEF_RAND_W,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [NUM_REQ-1:0] req,
    output logic               rng_rise,
    input  logic [RAND_W-1:0]  rng_dout,
    output logic [NUM_REQ-1:0] ack,
    output logic [RAND_W-1:0]  rand_out,
    output logic               busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t             state, nxt;
    logic [IDX_W-1:0]   ptr, win_q, pick;
    logic               pick_valid;
    logic               deliver;
    logic [NUM_REQ-1:0] req_eff;

    // The requester being acked this cycle still holds req; keep it out of the pick.
    assign req_eff = req & ~ack;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_core (
        .req    (req_eff),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

`ifdef RNG_REJECT_DUP_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] retry;
    logic [RAND_W-1:0]  last_val [NUM_REQ];

    assign deliver = !((rng_dout == last_val[win_q]) &&
                       (retry < RETRY_W'(MAX_RETRY)));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            retry <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) last_val[i] <= '0;
        end else if (state == CAPTURE) begin
            if (deliver) begin
                retry           <= '0;
                last_val[win_q] <= rng_dout;
            end else begin
                retry <= retry + 1'b1;
            end
        end
    end
`else
    assign deliver = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (pick_valid) nxt = PULSE;
            PULSE:   nxt = CAPTURE;
            CAPTURE: nxt = deliver ? IDLE : GAP;
            GAP:     nxt = PULSE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        rng_rise = 1'b0;
        busy     = 1'b0;
        if (state == PULSE) rng_rise = 1'b1;
        if (state != IDLE)  busy     = 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            win_q    <= '0;
            ptr      <= '0;
            ack      <= '0;
            rand_out <= '0;
        end else begin
            ack <= '0;
            if (state == IDLE && pick_valid) win_q <= pick;
            if (state == CAPTURE && deliver) begin
                rand_out <= rng_dout;
                ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
                ptr      <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Directed self-checking bench for rng_request_arbiter with a queue-driven generator model.
module tb_rng_request_arbiter;

    logic       clk = 1'b0;
    logic       resetN;
    logic [3:0] req;
    logic       rng_rise;
    logic [5:0] rng_dout;
    logic [3:0] ack;
    logic [5:0] rand_out;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rise_cnt = 0;
    int rise_adj = 0;
    int oh_viol  = 0;
    int ack_cyc  = 0;
    int prev_cyc = 0;
    int r0       = 0;
    logic prev_rise = 1'b0;
    logic [5:0] gen_q [$];

    always #5 clk = ~clk;

    rng_request_arbiter #(.NUM_REQ(4), .RAND_W(6), .MAX_RETRY(3)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .req      (req),
        .rng_rise (rng_rise),
        .rng_dout (rng_dout),
        .ack      (ack),
        .rand_out (rand_out),
        .busy     (busy)
    );

    // Generator model: latches the next queued value on each rise pulse.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) rng_dout <= '0;
        else if (rng_rise) begin
            if (gen_q.size() > 0) rng_dout <= gen_q.pop_front();
            else                  rng_dout <= rng_dout + 6'd1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rng_rise && prev_rise) rise_adj <= rise_adj + 1;
        if (rng_rise)              rise_cnt <= rise_cnt + 1;
        if ($countones(ack) > 1)   oh_viol  <= oh_viol + 1;
        prev_rise <= rng_rise;
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input logic [3:0] exp_ack, input logic [5:0] exp_val);
        for (int i = 0; i < 20; i++) begin
            step;
            if (ack !== 4'b0000) break;
        end
        chk({tag, " ack"}, {28'd0, ack}, {28'd0, exp_ack});
        chk({tag, " val"}, {26'd0, rand_out}, {26'd0, exp_val});
        ack_cyc = cyc;
    endtask

    initial begin
        resetN = 1'b0;
        req    = 4'b0000;
        step; step;
        chk("rst rise", {31'd0, rng_rise}, 0);
        chk("rst ack", {28'd0, ack}, 0);
        chk("rst rand", {26'd0, rand_out}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        resetN = 1'b1;
        step;

        // Single request
        gen_q.push_back(6'h2A);
        req = 4'b0001;
        step;
        chk("s1 pulse rise", {31'd0, rng_rise}, 1);
        chk("s1 pulse busy", {31'd0, busy}, 1);
        chk("s1 pulse ack", {28'd0, ack}, 0);
        step;
        chk("s1 cap rise", {31'd0, rng_rise}, 0);
        chk("s1 cap busy", {31'd0, busy}, 1);
        chk("s1 cap ack", {28'd0, ack}, 0);
        step;
        chk("s1 ack", {28'd0, ack}, 4'b0001);
        chk("s1 val", {26'd0, rand_out}, 6'h2A);
        chk("s1 idle busy", {31'd0, busy}, 0);
        step;
        req = 4'b0000;
        chk("s1 ack pulse end", {28'd0, ack}, 0);
        chk("s1 no regrant", {31'd0, busy}, 0);
        chk("s1 hold", {26'd0, rand_out}, 6'h2A);

        // Clean reset so the pointer starts at 0
        resetN = 1'b0;
        step;
        chk("rst2 rand", {26'd0, rand_out}, 0);
        resetN = 1'b1;
        step;

        // Contention: all four requesters held
        gen_q.push_back(6'h01);
        gen_q.push_back(6'h02);
        gen_q.push_back(6'h03);
        gen_q.push_back(6'h04);
        req = 4'b1111;
        wait_ack("c0", 4'b0001, 6'h01);
        for (int k = 1; k < 4; k++) begin
            prev_cyc = ack_cyc;
            step;
            req[k-1] = 1'b0;
            wait_ack("cn", 4'b0001 << k, 6'(k + 1));
            chk("c spacing", ack_cyc - prev_cyc, 3);
        end
        step;
        chk("c masked last", {31'd0, busy}, 0);
        req = 4'b0000;

        // Pointer wrap: serve requester 3, then 1001 -> requester 0 first
        gen_q.push_back(6'h05);
        gen_q.push_back(6'h06);
        gen_q.push_back(6'h07);
        req = 4'b1000;
        wait_ack("w3", 4'b1000, 6'h05);
        step;
        req = 4'b1001;
        wait_ack("w0", 4'b0001, 6'h06);
        step;
        req = 4'b1000;
        wait_ack("w3b", 4'b1000, 6'h07);
        step;
        chk("w idle", {31'd0, busy}, 0);
        req = 4'b0000;

        // Withdraw during PULSE
        gen_q.push_back(6'h08);
        req = 4'b0100;
        step;
        chk("wd rise", {31'd0, rng_rise}, 1);
        req = 4'b0000;
        wait_ack("wd", 4'b0100, 6'h08);
        step;
        chk("wd idle", {31'd0, busy}, 0);

        // Reset during PULSE
        req = 4'b0010;
        step;
        chk("rm rise pre", {31'd0, rng_rise}, 1);
        #2 resetN = 1'b0;
        #1;
        chk("rm rise", {31'd0, rng_rise}, 0);
        chk("rm ack", {28'd0, ack}, 0);
        chk("rm rand", {26'd0, rand_out}, 0);
        chk("rm busy", {31'd0, busy}, 0);
        req = 4'b0000;
        step;
        resetN = 1'b1;
        step;
        chk("rm no ack", {28'd0, ack}, 0);
        gen_q.push_back(6'h15);
        gen_q.push_back(6'h33);
        req = 4'b1010;
        wait_ack("rm p1", 4'b0010, 6'h15);
        step;
        req = 4'b1000;
        wait_ack("rm p3", 4'b1000, 6'h33);
        step;
        req = 4'b0000;
        chk("rm idle", {31'd0, busy}, 0);

`ifdef RNG_REJECT_DUP_EN
        gen_q.push_back(6'h10);
        req = 4'b0010;
        wait_ack("d seed", 4'b0010, 6'h10);
        step;
        req = 4'b0000;
        r0 = rise_cnt;
        gen_q.push_back(6'h10);
        gen_q.push_back(6'h10);
        gen_q.push_back(6'h11);
        req = 4'b0010;
        wait_ack("d retry", 4'b0010, 6'h11);
        step;
        req = 4'b0000;
        chk("d retry rises", rise_cnt - r0, 3);
        gen_q.push_back(6'h10);
        req = 4'b0010;
        wait_ack("d reseed", 4'b0010, 6'h10);
        step;
        req = 4'b0000;
        r0 = rise_cnt;
        for (int i = 0; i < 4; i++) gen_q.push_back(6'h10);
        req = 4'b0010;
        wait_ack("d giveup", 4'b0010, 6'h10);
        step;
        req = 4'b0000;
        chk("d giveup rises", rise_cnt - r0, 4);
`endif

        step;
        chk("rise adjacency", rise_adj, 0);
        chk("ack onehot", oh_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
